// File: rtl/ui_rom_arbiter.sv
// Shares the UI menu/game-over ROM read port between the VGA fetcher (priority) and a mouse hit-test engine.
// Latency: VGA data valid ROM_LAT+1 cycles after acceptance; hit_done ROM_LAT+2 cycles after hit_req when uncontended.
// Backpressure: a VGA request is held by the requester until vga_ready; a waiting hit-test is force-granted after STARVE_LIMIT cycles.
module ui_rom_arbiter #(
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 15,
    parameter int SPLIT_Y      = 310
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vga_req,
    input  logic [16:0] vga_addr,
    output logic        vga_ready,
    output logic        vga_valid,
    output logic [1:0]  vga_menu_px,
    output logic [1:0]  vga_over_px,
    input  logic        hit_req,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    output logic        hit_busy,
    output logic        hit_done,
    output logic        on_start,
    output logic        on_connect,
    output logic        on_return,
    output logic        rom_en,
    output logic [16:0] rom_addr,
    input  logic [1:0]  menu_dout,
    input  logic [1:0]  over_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_INFLIGHT,
        S_DONE
    } state_t;

    localparam int              CW     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT  = CW'(STARVE_LIMIT);
    localparam logic [9:0]      SPLIT  = 10'(SPLIT_Y);
    localparam logic [17:0]     SCREEN = 18'd76800;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wait_cnt;
    logic [16:0]         r_hit_addr;
    logic                r_y_hi;
    logic [ROM_LAT-1:0]  r_tag_vld;
    logic [ROM_LAT-1:0]  r_tag_hit;

    logic                w_hit_start;
    logic                w_hit_grant;
    logic                w_out_vld;
    logic                w_out_hit;
    logic [17:0]         w_x_half;
    logic [17:0]         w_y_half;
    logic [17:0]         w_lin;
    logic [17:0]         w_red1;
    logic [16:0]         w_hit_addr;

    // Linear pixel index on the 320x240 ROM; the 10-bit mouse range can overshoot by
    // up to two screens, hence the two conditional subtractions.
    assign w_x_half   = {8'd0, mouse_x} >> 1;
    assign w_y_half   = {8'd0, mouse_y} >> 1;
    assign w_lin      = w_x_half + (w_y_half << 8) + (w_y_half << 6);
    assign w_red1     = (w_lin >= SCREEN) ? (w_lin - SCREEN) : w_lin;
    assign w_hit_addr = 17'((w_red1 >= SCREEN) ? (w_red1 - SCREEN) : w_red1);

    assign w_hit_start = (r_state == S_IDLE) && hit_req;
    assign w_hit_grant = (r_state == S_WAIT) && (!vga_req || (r_wait_cnt == LIMIT));

    // Reset gating keeps the combinational outputs quiet while rst_n is low.
    assign vga_ready = rst_n && vga_req && !w_hit_grant;
    assign rom_en    = vga_ready || w_hit_grant;
    assign rom_addr  = w_hit_grant ? r_hit_addr : (rst_n ? vga_addr : 17'd0);

    assign w_out_vld = r_tag_vld[ROM_LAT-1];
    assign w_out_hit = r_tag_hit[ROM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hit_busy    = (r_state != S_IDLE);
        hit_done    = 1'b0;
        case (r_state)
            S_IDLE:     if (hit_req) w_state_nxt = S_WAIT;
            S_WAIT:     if (w_hit_grant) w_state_nxt = S_INFLIGHT;
            S_INFLIGHT: if (w_out_vld && w_out_hit) w_state_nxt = S_DONE;
            S_DONE: begin
                hit_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_hit_addr <= '0;
            r_y_hi     <= 1'b0;
        end else if (w_hit_start) begin
            r_wait_cnt <= '0;
            r_hit_addr <= w_hit_addr;
            r_y_hi     <= (mouse_y >= SPLIT);
        end else if ((r_state == S_WAIT) && !w_hit_grant && (r_wait_cnt != LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Tags travel alongside the ROM pipeline so returning data is steered without reordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_hit <= '0;
        end else begin
            r_tag_vld[0] <= rom_en;
            r_tag_hit[0] <= w_hit_grant;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_hit[i] <= r_tag_hit[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_valid   <= 1'b0;
            vga_menu_px <= 2'd0;
            vga_over_px <= 2'd0;
        end else begin
            vga_valid <= w_out_vld && !w_out_hit;
            if (w_out_vld && !w_out_hit) begin
                vga_menu_px <= menu_dout;
                vga_over_px <= over_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_start   <= 1'b0;
            on_connect <= 1'b0;
            on_return  <= 1'b0;
        end else if (w_out_vld && w_out_hit) begin
            on_start   <= !r_y_hi && menu_dout[1];
            on_connect <= r_y_hi && menu_dout[1];
            on_return  <= (over_dout == 2'd2);
        end
    end

endmodule

// File: tb/tb_ui_rom_arbiter.sv
// Directed bench for ui_rom_arbiter with ROM_LAT=1, STARVE_LIMIT=15, SPLIT_Y=310.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ui_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vga_req = 1'b0;
    logic [16:0] vga_addr = '0;
    logic        hit_req = 1'b0;
    logic [9:0]  mouse_x = '0;
    logic [9:0]  mouse_y = '0;
    logic [1:0]  menu_dout = '0;
    logic [1:0]  over_dout = '0;

    logic        vga_ready, vga_valid, hit_busy, hit_done;
    logic [1:0]  vga_menu_px, vga_over_px;
    logic        on_start, on_connect, on_return, rom_en;
    logic [16:0] rom_addr;

    logic        rom_force = 1'b0;
    logic [1:0]  force_menu = '0;
    logic [1:0]  force_over = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One-cycle synchronous ROM: data is addr[1:0] unless forced for a hit scenario.
    always @(posedge clk) begin
        if (rom_en) begin
            menu_dout <= rom_force ? force_menu : rom_addr[1:0];
            over_dout <= rom_force ? force_over : rom_addr[1:0];
        end
    end

    ui_rom_arbiter #(.ROM_LAT(1), .STARVE_LIMIT(15), .SPLIT_Y(310)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ready(vga_ready),
        .vga_valid(vga_valid), .vga_menu_px(vga_menu_px), .vga_over_px(vga_over_px),
        .hit_req(hit_req), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .hit_busy(hit_busy), .hit_done(hit_done),
        .on_start(on_start), .on_connect(on_connect), .on_return(on_return),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .menu_dout(menu_dout), .over_dout(over_dout)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [28:0] all_out;
        rst_n = 1'b0;
        #2;
        all_out = {vga_ready, vga_valid, vga_menu_px, vga_over_px, hit_busy, hit_done,
                   on_start, on_connect, on_return, rom_en, rom_addr};
        checks++;
        if (all_out !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (hit_busy !== 1'b0 || vga_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", hit_busy, vga_valid);
        end
        next_cycle();
    endtask

    task automatic test_lone_vga;
        rom_force = 1'b0;
        vga_req = 1'b1;
        vga_addr = 17'd0;
        @(negedge clk);
        checks++;
        if (vga_ready !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 17'd0) begin
            errors++;
            $display("FAIL vga_c0: got ready=%b en=%b addr=%0d expected 1 1 0", vga_ready, rom_en, rom_addr);
        end
        next_cycle();
        vga_addr = 17'd76799;
        @(negedge clk);
        checks++;
        if (vga_ready !== 1'b1 || rom_addr !== 17'd76799) begin
            errors++;
            $display("FAIL vga_c1: got ready=%b addr=%0d expected 1 76799", vga_ready, rom_addr);
        end
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        checks++;
        if (vga_valid !== 1'b1 || vga_menu_px !== 2'd0 || vga_over_px !== 2'd0) begin
            errors++;
            $display("FAIL vga_c2: got valid=%b px=%0d/%0d expected 1 0/0", vga_valid, vga_menu_px, vga_over_px);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (vga_valid !== 1'b1 || vga_menu_px !== 2'd3 || vga_over_px !== 2'd3) begin
            errors++;
            $display("FAIL vga_c3: got valid=%b px=%0d/%0d expected 1 3/3", vga_valid, vga_menu_px, vga_over_px);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (vga_valid !== 1'b0) begin
            errors++;
            $display("FAIL vga_c4: got valid=%b expected 0", vga_valid);
        end
        next_cycle();
    endtask

    task automatic test_lone_hit;
        rom_force = 1'b1;
        force_menu = 2'd2;
        force_over = 2'd0;
        mouse_x = 10'd100;
        mouse_y = 10'd100;
        hit_req = 1'b1;
        @(negedge clk);
        checks++;
        if (hit_busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_c0_busy: got %b expected 0", hit_busy);
        end
        next_cycle();
        hit_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 17'd16050 || hit_busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_c1: got en=%b addr=%0d busy=%b expected 1 16050 1", rom_en, rom_addr, hit_busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (hit_done !== 1'b0) begin
            errors++;
            $display("FAIL hit_c2_done: got %b expected 0", hit_done);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (hit_done !== 1'b1 || {on_start, on_connect, on_return} !== 3'b100) begin
            errors++;
            $display("FAIL hit_c3: got done=%b flags=%b expected 1 100", hit_done, {on_start, on_connect, on_return});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (hit_done !== 1'b0 || hit_busy !== 1'b0 || on_start !== 1'b1) begin
            errors++;
            $display("FAIL hit_c4: got done=%b busy=%b start=%b expected 0 0 1", hit_done, hit_busy, on_start);
        end
        next_cycle();
    endtask

    task automatic test_addr_wrap;
        logic [9:0]  xs [2] = '{10'd639, 10'd1023};
        logic [9:0]  ys [2] = '{10'd479, 10'd1023};
        logic [16:0] ex [2] = '{17'd76799, 17'd10431};
        rom_force = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mouse_x = xs[i];
            mouse_y = ys[i];
            hit_req = 1'b1;
            next_cycle();
            hit_req = 1'b0;
            @(negedge clk);
            checks++;
            if (rom_en !== 1'b1 || rom_addr !== ex[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got en=%b addr=%0d expected 1 %0d", i, rom_en, rom_addr, ex[i]);
            end
            next_cycle();
            next_cycle();
            @(negedge clk);
            checks++;
            if (hit_done !== 1'b1) begin
                errors++;
                $display("FAIL wrap_done%0d: got %b expected 1", i, hit_done);
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation;
        logic [16:0] q[$];
        logic [16:0] exp_a;
        logic        acc;
        int          pops;
        rom_force = 1'b0;
        mouse_x = 10'd0;
        mouse_y = 10'd0;
        vga_addr = 17'd200;
        vga_req = 1'b1;
        hit_req = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc == 1) hit_req = 1'b0;
            if (cyc == 21) vga_req = 1'b0;
            @(negedge clk);
            if (vga_req) begin
                checks++;
                if (vga_ready !== (cyc != 16)) begin
                    errors++;
                    $display("FAIL starve_ready_c%0d: got %b expected %b", cyc, vga_ready, (cyc != 16));
                end
            end
            if (cyc == 16) begin
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== 17'd0) begin
                    errors++;
                    $display("FAIL starve_grant: got en=%b addr=%0d expected 1 0", rom_en, rom_addr);
                end
            end
            checks++;
            if (hit_done !== (cyc == 18)) begin
                errors++;
                $display("FAIL starve_done_c%0d: got %b expected %b", cyc, hit_done, (cyc == 18));
            end
            acc = vga_ready;
            if (acc) q.push_back(vga_addr);
            if (vga_valid) begin
                pops++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL starve_order_c%0d: got unexpected vga_valid expected none", cyc);
                end else begin
                    exp_a = q.pop_front();
                    if (vga_menu_px !== exp_a[1:0] || vga_over_px !== exp_a[1:0]) begin
                        errors++;
                        $display("FAIL starve_order_c%0d: got px=%0d/%0d expected %0d", cyc, vga_menu_px, vga_over_px, exp_a[1:0]);
                    end
                end
            end
            next_cycle();
            if (acc) vga_addr = vga_addr + 17'd1;
        end
        checks++;
        if (pops != 20 || q.size() != 0) begin
            errors++;
            $display("FAIL starve_count: got %0d returned, %0d pending expected 20 0", pops, q.size());
        end
    endtask

    task automatic test_split_return;
        logic [9:0] ys [3] = '{10'd320, 10'd309, 10'd310};
        logic [1:0] mm [3] = '{2'd3, 2'd2, 2'd2};
        logic [1:0] oo [3] = '{2'd2, 2'd1, 2'd3};
        logic [2:0] ef [3] = '{3'b011, 3'b100, 3'b010};
        rom_force = 1'b1;
        mouse_x = 10'd0;
        for (int i = 0; i < 3; i++) begin
            mouse_y = ys[i];
            force_menu = mm[i];
            force_over = oo[i];
            hit_req = 1'b1;
            next_cycle();
            hit_req = 1'b0;
            next_cycle();
            next_cycle();
            @(negedge clk);
            checks++;
            if (hit_done !== 1'b1 || {on_start, on_connect, on_return} !== ef[i]) begin
                errors++;
                $display("FAIL split%0d: got done=%b flags=%b expected 1 %b", i, hit_done, {on_start, on_connect, on_return}, ef[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight;
        logic [28:0] all_out;
        rom_force = 1'b0;
        vga_req = 1'b1;
        vga_addr = 17'd5;
        hit_req = 1'b1;
        mouse_x = 10'd100;
        mouse_y = 10'd100;
        @(negedge clk);
        checks++;
        if (vga_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_vga_grant: got %b expected 1", vga_ready);
        end
        next_cycle();
        vga_req = 1'b0;
        hit_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 17'd16050) begin
            errors++;
            $display("FAIL rst_hit_grant: got en=%b addr=%0d expected 1 16050", rom_en, rom_addr);
        end
        next_cycle();
        rst_n = 1'b0;
        vga_req = 1'b1;
        hit_req = 1'b1;
        #1;
        all_out = {vga_ready, vga_valid, vga_menu_px, vga_over_px, hit_busy, hit_done,
                   on_start, on_connect, on_return, rom_en, rom_addr};
        checks++;
        if (all_out !== 29'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0", all_out);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        vga_req = 1'b0;
        hit_req = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            checks++;
            if (vga_valid !== 1'b0 || hit_done !== 1'b0 || hit_busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet_c%0d: got valid=%b done=%b busy=%b expected 0 0 0", cyc, vga_valid, hit_done, hit_busy);
            end
            next_cycle();
        end
        rom_force = 1'b1;
        force_menu = 2'd2;
        force_over = 2'd0;
        hit_req = 1'b1;
        next_cycle();
        hit_req = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (hit_done !== 1'b1 || {on_start, on_connect, on_return} !== 3'b100) begin
            errors++;
            $display("FAIL rst_rehit: got done=%b flags=%b expected 1 100", hit_done, {on_start, on_connect, on_return});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_lone_vga();
        test_lone_hit();
        test_addr_wrap();
        test_starvation();
        test_split_return();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ui_rom_arbiter.md
# ui_rom_arbiter

Shares the single read port of the UI screen ROMs (menu ROM and game-over ROM, both 2-bit, 320x240, same address map) between two requesters. The VGA pixel fetcher is the first requester. The second is a mouse hit-test engine that turns a mouse position into button-hover flags. VGA has priority, and a starvation counter guarantees that hit-tests complete. The block sits between the VGA/mouse logic and the two block ROM instances.

## Interface
Parameters:
- ROM_LAT, 1, ROM read latency in cycles (legal 1..4)
- STARVE_LIMIT, 15, number of consecutive waiting cycles after which a hit-test is force-granted over VGA
- SPLIT_Y, 310, Y boundary between the start button and the connect button

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA wants a ROM read this cycle
- vga_addr  in  17  VGA ROM address (0..76799)
- vga_ready  out  1  VGA request accepted this cycle (combinational)
- vga_valid  out  1  one-cycle pulse; VGA pixel data is valid
- vga_menu_px  out  2  menu ROM data for the accepted VGA read
- vga_over_px  out  2  over ROM data for the accepted VGA read
- hit_req  in  1  start a hit-test (sampled in IDLE only)
- mouse_x  in  10  mouse X, 640-wide screen
- mouse_y  in  10  mouse Y, 480-tall screen
- hit_busy  out  1  hit-test in progress
- hit_done  out  1  one-cycle pulse; hover flags updated
- on_start  out  1  hover flag for the start button, held until the next hit_done
- on_connect  out  1  hover flag for the connect button, held until the next hit_done
- on_return  out  1  hover flag for the return button, held until the next hit_done
- rom_en  out  1  ROM read enable (combinational)
- rom_addr  out  17  shared ROM address (combinational)
- menu_dout  in  2  menu ROM data
- over_dout  in  2  over ROM data

## Operation
- Hit-test FSM states: IDLE, WAIT, INFLIGHT, DONE.
- IDLE:
  - On hit_req, latch mouse_x, mouse_y and latch y_hi = (mouse_y >= SPLIT_Y).
  - Register the hit address, then go to WAIT.
  - hit_req in any other state is ignored.
- Hit address arithmetic:
  - a = (mouse_x>>1) + 320*(mouse_y>>1), computed in 18 bits (max 164031).
  - Reduce a modulo 76800 with two conditional subtractions of 76800.
  - Result is 17 bits.
- Arbitration in a cycle where the FSM is in WAIT:
  - hit_grant = !vga_req || (wait_cnt == STARVE_LIMIT).
  - On hit_grant: rom_addr = hit address, vga_ready = 0, FSM goes to INFLIGHT.
- In all other cases:
  - vga_ready = vga_req.
  - rom_addr = vga_addr.
- rom_en = vga_ready || hit_grant.
- wait_cnt:
  - Clears on entry to WAIT.
  - Increments on each WAIT cycle without a grant.
  - Saturates at STARVE_LIMIT.
- In-flight tracking: a ROM_LAT-deep shift register of {valid, is_hit} tags. There is at most one hit tag in flight.
- When a VGA tag emerges:
  - Register menu_dout and over_dout into the px outputs.
  - Pulse vga_valid the next cycle.
- When the hit tag emerges:
  - on_start = !y_hi && menu_dout[1].
  - on_connect = y_hi && menu_dout[1].
  - on_return = (over_dout == 2).
  - FSM goes to DONE.
- DONE: hit_done = 1 for one cycle, then the FSM returns to IDLE.
- hit_busy = (state != IDLE).
- VGA reads are never reordered or dropped. A VGA request that is not granted must be held by the requester.

## Timing
- Reset values: all outputs 0; FSM in IDLE; tags cleared; wait_cnt 0; hover flags 0.
- Reset mid-operation flushes everything. No vga_valid or hit_done is produced for requests issued before reset.
- VGA latency: request accepted in cycle t produces vga_valid in cycle t+ROM_LAT+1. With ROM_LAT=1 that is cycle t+2.
- Hit latency (ROM_LAT=1, no contention):
  - hit_req in cycle 0; WAIT and grant in cycle 1.
  - Data in cycle 2.
  - hit_done in cycle 3.
  - Flags are valid from cycle 3.
- Worst-case hit_done is cycle STARVE_LIMIT+3 under continuous vga_req.
- Back-to-back VGA reads, one per cycle, are sustained whenever no hit grant occurs.
- In a forced-grant cycle, vga_ready = 0 for that single cycle only.

## Test plan
- Lone VGA:
  - Stimulus: vga_req with addr 0 then addr 76799, ROM model returning addr[1:0].
  - Required: vga_ready = 1 both cycles; vga_valid in cycles 2 and 3; px = 0 then 3.
- Lone hit:
  - Stimulus: x=100, y=100, hit_req pulse.
  - Required: rom_addr = 16050 in cycle 1; menu_dout = 2 gives on_start = 1 and on_connect = 0; hit_done in cycle 3.
- Address wrap:
  - Stimulus: x=639, y=479, then x=1023, y=1023.
  - Required: rom_addr = 76799, then rom_addr = 10431.
- Starvation:
  - Stimulus: vga_req held high, hit_req in cycle 0.
  - Required: hit granted in cycle STARVE_LIMIT+1 (16) with vga_ready = 0 that cycle only; hit_done in cycle 18; VGA data order intact.
- Split and return:
  - Stimulus: y=320 with menu_dout = 3 and over_dout = 2.
  - Required: on_connect = 1, on_start = 0, on_return = 1.
- Reset mid-flight:
  - Stimulus: assert rst_n = 0 in the cycle after both a VGA grant and a hit grant.
  - Required: all outputs 0 immediately; no vga_valid or hit_done afterwards; a new hit_req after release completes normally.
